// File: rtl/mul_wb_scheduler_pkg.sv
// Shared constants and types for the multiply/writeback issue scheduler.
// Defaults match the pipeline's register-address width and pipe latencies.
package mul_wb_scheduler_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int MUL_LAT_DEF = 5;
    localparam int ALU_LAT_DEF = 3;
    localparam int CNT_W_DEF   = 3;

    // Per-cycle action on the in-flight multiply counter
    typedef enum logic [1:0] {
        INF_HOLD = 2'd0,
        INF_INC  = 2'd1,
        INF_DEC  = 2'd2
    } inf_op_e;

endpackage

// File: rtl/mul_track_slot.sv
// One entry of the pending-multiply shift array: a registered {valid, dest}
// pair compared against both decode sources and the decode destination.
import mul_wb_scheduler_pkg::*;

module mul_track_slot #(
    parameter int REG_ADDR = REG_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    input  logic [REG_ADDR-1:0] load_dest,
    input  logic [REG_ADDR-1:0] src1,
    input  logic [REG_ADDR-1:0] src2,
    input  logic [REG_ADDR-1:0] dest_cmp,
    output logic                valid,
    output logic [REG_ADDR-1:0] dest,
    output logic                match_src1,
    output logic                match_src2,
    output logic                match_dest
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            dest  <= '0;
        end else begin
            valid <= load_valid;
            dest  <= load_dest;
        end
    end

    // A valid entry never holds r0, so a match implies a nonzero register.
    assign match_src1 = valid & (dest == src1);
    assign match_src2 = valid & (dest == src2);
    assign match_dest = valid & (dest == dest_cmp);

endmodule

// File: rtl/mul_wb_scheduler.sv
// Issue scheduler between decode and the ALU/memory and multiply pipes:
// tracks pending multiplies, stalls on hazards and write-port collisions.
import mul_wb_scheduler_pkg::*;

module mul_wb_scheduler #(
    parameter int REG_ADDR = REG_ADDR_W,
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int ALU_LAT  = ALU_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_valid,
    input  logic                d_is_mult,
    input  logic                d_regwrite,
    input  logic [REG_ADDR-1:0] d_dest_reg,
    input  logic [REG_ADDR-1:0] d_src1,
    input  logic [REG_ADDR-1:0] d_src2,
    input  logic                flush,
    output logic                d_stall,
    output logic                mul_issue,
    output logic                alu_issue,
    output logic                wb_mul_sel,
    output logic [REG_ADDR-1:0] wb_mul_dest,
    output logic [CNT_W-1:0]    mul_inflight
);

    // Handshake: decode offers an instruction with d_valid; it is accepted
    // (mul_issue or alu_issue) in the same cycle unless d_stall is high, in
    // which case decode must hold it. flush withdraws the offer for one cycle.

    logic                req;
    logic                alu_wr;
    logic                raw;
    logic                waw;
    logic                port_conflict;
    logic                rec_valid;

    logic [MUL_LAT:1]    e_valid;
    logic [REG_ADDR-1:0] e_dest [1:MUL_LAT];
    logic [MUL_LAT:1]    m_src1;
    logic [MUL_LAT:1]    m_src2;
    logic [MUL_LAT:1]    m_dest;

    // Issue-age pipe counts every multiply, recorded or not.
    logic [MUL_LAT:1]    age;
    inf_op_e             inf_op;

    assign rec_valid = mul_issue & d_regwrite & (d_dest_reg != '0);

    for (genvar k = 1; k <= MUL_LAT; k++) begin : g_slot
        logic                nxt_valid;
        logic [REG_ADDR-1:0] nxt_dest;

        if (k == MUL_LAT) begin : g_head
            assign nxt_valid = rec_valid;
            assign nxt_dest  = d_dest_reg;
        end else begin : g_body
            assign nxt_valid = e_valid[k+1];
            assign nxt_dest  = e_dest[k+1];
        end

        mul_track_slot #(
            .REG_ADDR (REG_ADDR)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .load_valid (nxt_valid),
            .load_dest  (nxt_dest),
            .src1       (d_src1),
            .src2       (d_src2),
            .dest_cmp   (d_dest_reg),
            .valid      (e_valid[k]),
            .dest       (e_dest[k]),
            .match_src1 (m_src1[k]),
            .match_src2 (m_src2[k]),
            .match_dest (m_dest[k])
        );
    end

    assign req    = d_valid & ~flush;
    assign alu_wr = req & ~d_is_mult & d_regwrite;

    assign raw = req & (((|m_src1) & (d_src1 != '0)) |
                        ((|m_src2) & (d_src2 != '0)));
    assign waw = alu_wr & (d_dest_reg != '0) & (|m_dest);

    // An ALU op issued now writes in the same cycle as the multiply that
    // will sit in slot ALU_LAT after this edge, i.e. slot ALU_LAT+1 today.
    assign port_conflict = alu_wr & e_valid[ALU_LAT+1];

    assign d_stall   = raw | waw | port_conflict;
    assign mul_issue = req &  d_is_mult & ~d_stall;
    assign alu_issue = req & ~d_is_mult & ~d_stall;

    always_comb begin
        inf_op = INF_HOLD;
        if (mul_issue & ~age[1]) begin
            inf_op = INF_INC;
        end else if (~mul_issue & age[1]) begin
            inf_op = INF_DEC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age          <= '0;
            mul_inflight <= '0;
            wb_mul_sel   <= 1'b0;
            wb_mul_dest  <= '0;
        end else begin
            age         <= {mul_issue, age[MUL_LAT:2]};
            wb_mul_sel  <= e_valid[1];
            wb_mul_dest <= e_dest[1];
            case (inf_op)
                INF_INC: mul_inflight <= mul_inflight + CNT_W'(1);
                INF_DEC: mul_inflight <= mul_inflight - CNT_W'(1);
                default: mul_inflight <= mul_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// Bench for mul_wb_scheduler: directed vector table, randomized traffic
// against a write-cycle based reference model, and a mid-flight reset.
module tb_mul_wb_scheduler;

  localparam int RA = 5;
  localparam int ML = 5;
  localparam int AL = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          d_valid, d_is_mult, d_regwrite, flush;
  logic [RA-1:0] d_dest_reg, d_src1, d_src2;
  logic          d_stall, mul_issue, alu_issue, wb_mul_sel;
  logic [RA-1:0] wb_mul_dest;
  logic [CW-1:0] mul_inflight;

  // clock / reset
  always #5 clk = ~clk;

  mul_wb_scheduler #(.REG_ADDR(RA), .MUL_LAT(ML), .ALU_LAT(AL), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_valid      (d_valid),
    .d_is_mult    (d_is_mult),
    .d_regwrite   (d_regwrite),
    .d_dest_reg   (d_dest_reg),
    .d_src1       (d_src1),
    .d_src2       (d_src2),
    .flush        (flush),
    .d_stall      (d_stall),
    .mul_issue    (mul_issue),
    .alu_issue    (alu_issue),
    .wb_mul_sel   (wb_mul_sel),
    .wb_mul_dest  (wb_mul_dest),
    .mul_inflight (mul_inflight)
  );

  typedef struct {
    logic          v, m, w;
    logic [RA-1:0] dst, s1, s2;
    logic          fl;
    logic          e_stall, e_mul, e_alu, e_sel;
    logic [RA-1:0] e_dest;
    logic [CW-1:0] e_cnt;
  } vec_t;

  typedef struct {
    int            it;
    logic [RA-1:0] dst;
    bit            rec;
  } mul_t;

  vec_t          vecs[$];
  mul_t          mq[$];
  logic [RA-1:0] exp_q[$];
  int            t;
  int            n_vec;
  int            n_bad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, t, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic m, input logic w, input logic [RA-1:0] dst,
                       input logic [RA-1:0] s1, input logic [RA-1:0] s2, input logic fl);
    d_valid    = v;
    d_is_mult  = m;
    d_regwrite = w;
    d_dest_reg = dst;
    d_src1     = s1;
    d_src2     = s2;
    flush      = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    t++;
  endtask

  function automatic void av(input logic v, input logic m, input logic w, input logic [RA-1:0] dst,
                             input logic [RA-1:0] s1, input logic [RA-1:0] s2, input logic fl,
                             input logic st, input logic mi, input logic ai, input logic sel,
                             input logic [RA-1:0] wd, input logic [CW-1:0] cnt);
    vec_t r;
    r.v = v; r.m = m; r.w = w; r.dst = dst; r.s1 = s1; r.s2 = s2; r.fl = fl;
    r.e_stall = st; r.e_mul = mi; r.e_alu = ai; r.e_sel = sel; r.e_dest = wd; r.e_cnt = cnt;
    vecs.push_back(r);
  endfunction

  function automatic void idle(input logic sel, input logic [RA-1:0] wd, input logic [CW-1:0] cnt);
    av(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sel, wd, cnt);
  endfunction

  // Reference model: a multiply issued in cycle i writes the register file
  // in cycle i+ML, is pending (unreadable) in cycles i+1..i+ML, counts as in
  // flight over the same window, and is announced by wb_mul_sel in i+ML+1.
  // An ALU op issued in cycle t writes in cycle t+AL.
  function automatic bit m_stall();
    bit req, alu_wr, raw, waw, port;
    req    = d_valid & ~flush;
    alu_wr = req & ~d_is_mult & d_regwrite;
    raw = 0; waw = 0; port = 0;
    foreach (mq[i]) begin
      if (mq[i].rec) begin
        if (t > mq[i].it && t <= mq[i].it + ML) begin
          if ((mq[i].dst == d_src1 && d_src1 != 0) || (mq[i].dst == d_src2 && d_src2 != 0)) raw = 1;
          if (mq[i].dst == d_dest_reg && d_dest_reg != 0) waw = 1;
        end
        if (mq[i].it + ML == t + AL) port = 1;
      end
    end
    return req & (raw | (alu_wr & waw) | (alu_wr & port));
  endfunction

  function automatic bit m_sel();
    bit s;
    s = 0;
    foreach (mq[i]) if (mq[i].rec && mq[i].it + ML + 1 == t) s = 1;
    return s;
  endfunction

  function automatic int m_cnt();
    int c;
    c = 0;
    foreach (mq[i]) if (t > mq[i].it && t <= mq[i].it + ML) c++;
    return c;
  endfunction

  // One cycle with the currently driven inputs, checked against the model.
  task automatic model_cycle();
    bit   es, em, ea, req;
    mul_t r;
    @(negedge clk);
    req = d_valid & ~flush;
    es  = m_stall();
    em  = req & d_is_mult & ~es;
    ea  = req & ~d_is_mult & ~es;
    check("stall", d_stall, es);
    check("mul_issue", mul_issue, em);
    check("alu_issue", alu_issue, ea);
    check("wb_mul_sel", wb_mul_sel, m_sel());
    check("mul_inflight", mul_inflight, m_cnt());
    if (m_sel()) begin
      if (exp_q.size() == 0) check("wb_scoreboard_empty", 1, 0);
      else check("wb_mul_dest", wb_mul_dest, exp_q.pop_front());
    end
    if (em) begin
      r.it  = t;
      r.dst = d_dest_reg;
      r.rec = d_regwrite && d_dest_reg != 0;
      mq.push_back(r);
      if (r.rec) exp_q.push_back(d_dest_reg);
    end
    next_cycle();
    while (mq.size() > 0 && mq[0].it + ML + 1 < t) void'(mq.pop_front());
  endtask

  task automatic rand_cycle();
    drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4, $urandom_range(0, 19) < 17,
          RA'($urandom_range(0, 7)), RA'($urandom_range(0, 7)), RA'($urandom_range(0, 7)),
          $urandom_range(0, 9) == 0);
    model_cycle();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    t = 0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // single mul r5, no dependents
    av(1,1,1,5,1,2,0, 0,1,0,0,0,0);
    repeat (5) idle(0,0,1);
    idle(1,5,0); idle(0,0,0);
    // mul r5 then add r6,r5,r1: RAW
    av(1,1,1,5,1,2,0, 0,1,0,0,0,0);
    repeat (5) av(1,0,1,6,5,1,0, 1,0,0,0,0,1);
    av(1,0,1,6,5,1,0, 0,0,1,1,5,0);
    idle(0,0,0);
    // mul r5 then independent ALU r7 at cycle 2: write-port conflict
    av(1,1,1,5,1,2,0, 0,1,0,0,0,0);
    idle(0,0,1);
    av(1,0,1,7,1,2,0, 1,0,0,0,0,1);
    av(1,0,1,7,1,2,0, 0,0,1,0,0,1);
    idle(0,0,1); idle(0,0,1); idle(1,5,0); idle(0,0,0);
    // mul r8 then add r8,r1,r2: WAW
    av(1,1,1,8,1,2,0, 0,1,0,0,0,0);
    repeat (5) av(1,0,1,8,1,2,0, 1,0,0,0,0,1);
    av(1,0,1,8,1,2,0, 0,0,1,1,8,0);
    idle(0,0,0);
    // mul r0, add r3,r0,r0, then flushed offers
    av(1,1,1,0,1,2,0, 0,1,0,0,0,0);
    av(1,0,1,3,0,0,0, 0,0,1,0,0,1);
    av(1,1,1,9,0,0,1, 0,0,0,0,0,1);
    av(1,0,1,9,0,0,1, 0,0,0,0,0,1);
    idle(0,0,1); idle(0,0,1); idle(0,0,0); idle(0,0,0);
    // flush masks a hazard but leaves the pending entry intact
    av(1,1,1,5,1,2,0, 0,1,0,0,0,0);
    av(1,0,1,6,5,0,1, 0,0,0,0,0,1);
    av(1,0,1,6,5,0,0, 1,0,0,0,0,1);
    idle(0,0,1); idle(0,0,1); idle(0,0,1); idle(1,5,0); idle(0,0,0);
    // back-to-back multiplies to the same dest
    av(1,1,1,4,1,2,0, 0,1,0,0,0,0);
    av(1,1,1,4,1,2,0, 0,1,0,0,0,1);
    repeat (4) idle(0,0,2);
    idle(1,4,1); idle(1,4,0); idle(0,0,0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_mul_sel", wb_mul_sel, 0);
    check("rst_wb_mul_dest", wb_mul_dest, 0);
    check("rst_mul_inflight", mul_inflight, 0);
    check("rst_stall", d_stall, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].m, vecs[i].w, vecs[i].dst, vecs[i].s1, vecs[i].s2, vecs[i].fl);
      @(negedge clk);
      check("tbl_stall", d_stall, vecs[i].e_stall);
      check("tbl_mul_issue", mul_issue, vecs[i].e_mul);
      check("tbl_alu_issue", alu_issue, vecs[i].e_alu);
      check("tbl_wb_mul_sel", wb_mul_sel, vecs[i].e_sel);
      check("tbl_mul_inflight", mul_inflight, vecs[i].e_cnt);
      if (vecs[i].e_sel) check("tbl_wb_mul_dest", wb_mul_dest, vecs[i].e_dest);
      next_cycle();
    end

    // randomized traffic against the model (table leaves nothing pending)
    mq.delete();
    exp_q.delete();
    repeat (600) rand_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (ML + 2) model_cycle();

    // three multiplies in flight, then asynchronous reset mid-cycle
    drive(1, 1, 1, 1, 0, 0, 0); model_cycle();
    drive(1, 1, 1, 2, 0, 0, 0); model_cycle();
    drive(1, 1, 1, 3, 0, 0, 0); model_cycle();
    drive(0, 0, 0, 0, 0, 0, 0); model_cycle();
    drive(1, 0, 1, 6, 1, 2, 0);
    #1;
    check("pre_rst_stall", d_stall, 1);
    reset = 1'b0;
    #1;
    check("async_rst_mul_inflight", mul_inflight, 0);
    check("async_rst_wb_mul_sel", wb_mul_sel, 0);
    check("async_rst_wb_mul_dest", wb_mul_dest, 0);
    check("async_rst_stall", d_stall, 0);
    check("async_rst_alu_issue", alu_issue, 1);
    mq.delete();
    exp_q.delete();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    t = 0;
    repeat (ML + 4) model_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
